sync_edge_filter: RTL and testbench

SYNC_EDGE_FILTER -- requirements
Module: sync_edge_filter

---
 rtl/sync_pkg.sv | 21 ++
 rtl/sync_filter_chan.sv | 74 +++++++
 rtl/sync_edge_filter.sv | 60 ++++++
 tb/tb_sync_edge_filter.sv | 325 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sync_pkg.sv
// Shared constants and helpers for the synchroniser / edge-filter slice.
// Holds the legal parameter minimums and the counter-width function.
package sync_pkg;

    localparam int NUM_STAGES_MIN = 2;
    localparam int FILTER_LEN_MIN = 1;

    // Number of bits needed to hold values 0 .. value-1.
    function automatic int clog2(input int value);
        int result;
        int remaining;
        result = 0;
        remaining = value - 1;
        while (remaining > 0) begin
            result = result + 1;
            remaining = remaining >> 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/sync_filter_chan.sv
// One channel: synchroniser chain, stability counter, filtered level and
// registered rise/fall pulses.
module sync_filter_chan
    import sync_pkg::*;
#(
    parameter int   NUM_STAGES = 2,
    parameter int   FILTER_LEN = 1,
    parameter logic RST_VAL    = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic level,
    output logic sync,
    output logic filt,
    output logic rise,
    output logic fall,
    output logic edge_next
);

    localparam int              CNT_W    = clog2(FILTER_LEN + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FILTER_LEN - 1);

    logic [NUM_STAGES-1:0] stages;
    logic [CNT_W-1:0]      cnt;
    logic [CNT_W-1:0]      cnt_next;
    logic                  filt_next;
    logic                  rise_next;
    logic                  fall_next;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stages <= {NUM_STAGES{RST_VAL}};
        end else begin
            stages <= {stages[NUM_STAGES-2:0], level};
        end
    end

    assign sync = stages[NUM_STAGES-1];

    // Any cycle of agreement, or a disabled filter, restarts qualification.
    always_comb begin
        cnt_next  = '0;
        filt_next = filt;
        rise_next = 1'b0;
        fall_next = 1'b0;
        if (en && (sync != filt)) begin
            if (cnt == CNT_LAST) begin
                filt_next = sync;
                rise_next = sync;
                fall_next = ~sync;
            end else begin
                cnt_next = cnt + 1'b1;
            end
        end
    end

    assign edge_next = rise_next | fall_next;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt  <= '0;
            filt <= RST_VAL;
            rise <= 1'b0;
            fall <= 1'b0;
        end else begin
            cnt  <= cnt_next;
            filt <= filt_next;
            rise <= rise_next;
            fall <= fall_next;
        end
    end

endmodule

// File: rtl/sync_edge_filter.sv
// Multi-channel synchroniser with per-channel deglitch filter and edge pulses.
// ANY_EDGE is registered from the channels' next-state pulses so it lines up with RISE/FALL.
module sync_edge_filter
    import sync_pkg::*;
#(
    parameter int   NUM_STAGES = 2,
    parameter int   BUS_WIDTH  = 1,
    parameter int   FILTER_LEN = 1,
    parameter logic RST_VAL    = 1'b0
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic                 EN,
    input  logic [BUS_WIDTH-1:0] ASYNC,
    output logic [BUS_WIDTH-1:0] SYNC,
    output logic [BUS_WIDTH-1:0] FILT,
    output logic [BUS_WIDTH-1:0] RISE,
    output logic [BUS_WIDTH-1:0] FALL,
    output logic                 ANY_EDGE
);

    if (NUM_STAGES < NUM_STAGES_MIN) begin : g_bad_stages
        $error("sync_edge_filter: NUM_STAGES must be >= %0d", NUM_STAGES_MIN);
    end
    if (FILTER_LEN < FILTER_LEN_MIN) begin : g_bad_filter
        $error("sync_edge_filter: FILTER_LEN must be >= %0d", FILTER_LEN_MIN);
    end
    if (BUS_WIDTH < 1) begin : g_bad_width
        $error("sync_edge_filter: BUS_WIDTH must be >= 1");
    end

    logic [BUS_WIDTH-1:0] edge_next;

    for (genvar i = 0; i < BUS_WIDTH; i++) begin : g_chan
        sync_filter_chan #(
            .NUM_STAGES (NUM_STAGES),
            .FILTER_LEN (FILTER_LEN),
            .RST_VAL    (RST_VAL)
        ) u_chan (
            .clk       (CLK),
            .rst       (RST),
            .en        (EN),
            .level     (ASYNC[i]),
            .sync      (SYNC[i]),
            .filt      (FILT[i]),
            .rise      (RISE[i]),
            .fall      (FALL[i]),
            .edge_next (edge_next[i])
        );
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            ANY_EDGE <= 1'b0;
        end else begin
            ANY_EDGE <= |edge_next;
        end
    end

endmodule

// File: tb/tb_sync_edge_filter.sv
// Bench for sync_edge_filter: two configurations checked against a window-based
// reference model (filtered value flips when the last FILTER_LEN enabled edges all disagreed).
module tb_sync_edge_filter;

    localparam int   N0 = 2;
    localparam int   W0 = 4;
    localparam int   F0 = 4;
    localparam logic RV0 = 1'b0;
    localparam int   N1 = 3;
    localparam int   W1 = 2;
    localparam int   F1 = 2;
    localparam logic RV1 = 1'b1;
    localparam int   HL = 16;

    logic       clk = 1'b0;
    logic       rst;
    logic       en;
    logic [3:0] async0, sync0, filt0, rise0, fall0;
    logic       any0;
    logic [1:0] async1, sync1, filt1, rise1, fall1;
    logic       any1;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    sync_edge_filter #(.NUM_STAGES(N0), .BUS_WIDTH(W0), .FILTER_LEN(F0), .RST_VAL(RV0)) dut0 (
        .CLK(clk), .RST(rst), .EN(en), .ASYNC(async0), .SYNC(sync0),
        .FILT(filt0), .RISE(rise0), .FALL(fall0), .ANY_EDGE(any0)
    );

    sync_edge_filter #(.NUM_STAGES(N1), .BUS_WIDTH(W1), .FILTER_LEN(F1), .RST_VAL(RV1)) dut1 (
        .CLK(clk), .RST(rst), .EN(en), .ASYNC(async1), .SYNC(sync1),
        .FILT(filt1), .RISE(rise1), .FALL(fall1), .ANY_EDGE(any1)
    );

    // Reference model state: input history (index 0 = newest edge) since reset.
    logic [3:0] ah0 [HL];
    bit         eh0 [HL];
    int         nv0;
    logic [3:0] m0_sync, m0_filt, m0_rise, m0_fall;
    logic       m0_any;
    logic [3:0] ah1 [HL];
    bit         eh1 [HL];
    int         nv1;
    logic [3:0] m1_sync, m1_filt, m1_rise, m1_fall;
    logic       m1_any;

    function automatic logic [3:0] sync_seen(input logic [3:0] ah [HL], input int nv,
                                             input int idx, input logic rv);
        return (idx < nv) ? ah[idx] : {4{rv}};
    endfunction

    task automatic model_step(input int n, input int f, input int w, input logic rv,
                              input logic [3:0] ah [HL], input bit eh [HL], input int nv,
                              input logic [3:0] filt_in,
                              output logic [3:0] filt_o, output logic [3:0] rise_o,
                              output logic [3:0] fall_o, output logic [3:0] sync_o);
        bit         flip;
        logic [3:0] s;
        filt_o = filt_in;
        rise_o = '0;
        fall_o = '0;
        for (int ch = 0; ch < w; ch++) begin
            flip = (nv >= f);
            for (int j = 0; j < f; j++) begin
                s = sync_seen(ah, nv, j + n, rv);
                if (!eh[j] || (s[ch] == filt_in[ch])) flip = 1'b0;
            end
            if (flip) begin
                filt_o[ch] = ~filt_in[ch];
                rise_o[ch] = filt_o[ch];
                fall_o[ch] = ~filt_o[ch];
            end
        end
        sync_o = sync_seen(ah, nv, n - 1, rv);
    endtask

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            nv0 = 0; m0_sync = {4{RV0}}; m0_filt = {4{RV0}}; m0_rise = '0; m0_fall = '0; m0_any = 1'b0;
            nv1 = 0; m1_sync = {4{RV1}}; m1_filt = {4{RV1}}; m1_rise = '0; m1_fall = '0; m1_any = 1'b0;
        end else begin
            for (int i = HL - 1; i > 0; i--) begin
                ah0[i] = ah0[i-1]; eh0[i] = eh0[i-1];
                ah1[i] = ah1[i-1]; eh1[i] = eh1[i-1];
            end
            ah0[0] = async0;
            eh0[0] = en;
            ah1[0] = {2'b00, async1};
            eh1[0] = en;
            if (nv0 < HL) nv0++;
            if (nv1 < HL) nv1++;
            model_step(N0, F0, W0, RV0, ah0, eh0, nv0, m0_filt, m0_filt, m0_rise, m0_fall, m0_sync);
            model_step(N1, F1, W1, RV1, ah1, eh1, nv1, m1_filt, m1_filt, m1_rise, m1_fall, m1_sync);
            m0_any = |(m0_rise | m0_fall);
            m1_any = |(m1_rise[1:0] | m1_fall[1:0]);
        end
    end

    task automatic tick;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset;
        rst = 1'b1; en = 1'b0; async0 = 4'b0000; async1 = 2'b11;
        #1;
        checks++;
        if ({sync0, filt0, rise0, fall0, any0} !== 17'b0) begin
            errors++;
            $display("[TB] FAIL reset_dut0: got %h expected 0", {sync0, filt0, rise0, fall0, any0});
        end
        checks++;
        if ({sync1, filt1, rise1, fall1, any1} !== 9'b11_11_00_00_0) begin
            errors++;
            $display("[TB] FAIL reset_dut1: got %b expected 111100000", {sync1, filt1, rise1, fall1, any1});
        end
        repeat (3) tick();
        rst = 1'b0;
        en  = 1'b1;
        repeat (6) tick();
        checks++;
        if ({sync0, filt0, rise0, fall0, any0} !== 17'b0 || {sync1, filt1, rise1, fall1, any1} !== 9'b11_11_00_00_0) begin
            errors++;
            $display("[TB] FAIL reset_release: dut0 %h dut1 %b, expected idle reset values",
                     {sync0, filt0, rise0, fall0, any0}, {sync1, filt1, rise1, fall1, any1});
        end
    endtask

    task automatic test_rise_latency;
        async0 = 4'b0001;
        for (int cyc = 1; cyc <= 8; cyc++) begin
            tick();
            checks++;
            if (sync0[0] !== 1'(cyc >= 2)) begin
                errors++;
                $display("[TB] FAIL latency_sync edge %0d: got %b expected %b", cyc, sync0[0], cyc >= 2);
            end
            checks++;
            if (filt0[0] !== 1'(cyc >= 6)) begin
                errors++;
                $display("[TB] FAIL latency_filt edge %0d: got %b expected %b", cyc, filt0[0], cyc >= 6);
            end
            checks++;
            if ({rise0, any0} !== ((cyc == 6) ? 5'b0001_1 : 5'b0000_0)) begin
                errors++;
                $display("[TB] FAIL latency_rise edge %0d: RISE/ANY got %b expected %b",
                         cyc, {rise0, any0}, (cyc == 6) ? 5'b0001_1 : 5'b0000_0);
            end
        end
    endtask

    task automatic test_short_pulse;
        async0 = 4'b0000;
        repeat (10) tick();
        checks++;
        if (filt0 !== 4'b0000) begin
            errors++;
            $display("[TB] FAIL short_pulse_setup: FILT got %b expected 0000", filt0);
        end
        for (int i = 0; i < 15; i++) begin
            async0 = (i < 3) ? 4'b0001 : 4'b0000;
            tick();
            checks++;
            if ({filt0, rise0, fall0, any0} !== 13'b0) begin
                errors++;
                $display("[TB] FAIL short_pulse cyc %0d: FILT/RISE/FALL/ANY got %b expected all 0",
                         i, {filt0, rise0, fall0, any0});
            end
        end
    endtask

    task automatic test_multi_channel;
        int any_count;
        any_count = 0;
        async0 = 4'b1010;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (any0 === 1'b1) begin
                any_count++;
                checks++;
                if (rise0 !== 4'b1010 || fall0 !== 4'b0000) begin
                    errors++;
                    $display("[TB] FAIL multi_pulse: RISE %b FALL %b expected 1010/0000", rise0, fall0);
                end
            end
        end
        checks++;
        if (any_count != 1) begin
            errors++;
            $display("[TB] FAIL multi_any_count: got %0d cycles expected 1", any_count);
        end
        checks++;
        if (filt0 !== 4'b1010) begin
            errors++;
            $display("[TB] FAIL multi_filt: got %b expected 1010", filt0);
        end
    endtask

    task automatic test_enable;
        en = 1'b0;
        async0 = 4'b0101;
        for (int i = 0; i < 10; i++) begin
            tick();
            checks++;
            if ({filt0, rise0, fall0, any0} !== {4'b1010, 9'b0}) begin
                errors++;
                $display("[TB] FAIL enable_hold cyc %0d: FILT/RISE/FALL/ANY got %b expected 1010 then 0s",
                         i, {filt0, rise0, fall0, any0});
            end
            checks++;
            if (sync0 !== ((i >= 1) ? 4'b0101 : 4'b1010)) begin
                errors++;
                $display("[TB] FAIL enable_sync cyc %0d: got %b expected %b", i, sync0,
                         (i >= 1) ? 4'b0101 : 4'b1010);
            end
        end
        en = 1'b1;
        for (int e = 1; e <= 6; e++) begin
            tick();
            checks++;
            if ({filt0, rise0, fall0} !== ((e >= 4) ? {4'b0101, ((e == 4) ? 8'b0101_1010 : 8'b0)}
                                                     : {4'b1010, 8'b0})) begin
                errors++;
                $display("[TB] FAIL enable_resume edge %0d: FILT/RISE/FALL got %b", e, {filt0, rise0, fall0});
            end
        end
    endtask

    task automatic test_reset_mid;
        async0 = 4'b0000;
        repeat (8) tick();
        async0 = 4'b0001;
        repeat (4) tick();
        #2 rst = 1'b1;
        #1;
        checks++;
        if ({sync0, filt0, rise0, fall0, any0} !== 17'b0) begin
            errors++;
            $display("[TB] FAIL reset_mid_instant: got %h expected 0", {sync0, filt0, rise0, fall0, any0});
        end
        tick();
        tick();
        rst = 1'b0;
        for (int e = 1; e <= 9; e++) begin
            tick();
            checks++;
            if ({filt0[0], rise0[0]} !== {1'(e >= N0 + F0), 1'(e == N0 + F0)}) begin
                errors++;
                $display("[TB] FAIL reset_mid_requal edge %0d: FILT/RISE got %b expected %b",
                         e, {filt0[0], rise0[0]}, {e >= N0 + F0, e == N0 + F0});
            end
        end
    endtask

    task automatic test_random;
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 5) == 0) async0 = 4'($urandom);
            if ($urandom_range(0, 3) == 0) async1 = 2'($urandom);
            en  = ($urandom_range(0, 9) != 0);
            rst = ($urandom_range(0, 149) == 0);
            tick();
            checks++;
            if ({sync0, filt0, rise0, fall0, any0} !== {m0_sync, m0_filt, m0_rise, m0_fall, m0_any}) begin
                errors++;
                $display("[TB] FAIL random_dut0 cyc %0d: got %h expected %h", i,
                         {sync0, filt0, rise0, fall0, any0}, {m0_sync, m0_filt, m0_rise, m0_fall, m0_any});
            end
            checks++;
            if ({sync1, filt1, rise1, fall1, any1} !==
                {m1_sync[1:0], m1_filt[1:0], m1_rise[1:0], m1_fall[1:0], m1_any}) begin
                errors++;
                $display("[TB] FAIL random_dut1 cyc %0d: got %b expected %b", i,
                         {sync1, filt1, rise1, fall1, any1},
                         {m1_sync[1:0], m1_filt[1:0], m1_rise[1:0], m1_fall[1:0], m1_any});
            end
        end
        rst = 1'b0;
        en  = 1'b1;
    endtask

    task automatic test_rstval_one;
        async1 = 2'b11;
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        en  = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            checks++;
            if ({filt1, rise1, fall1, any1} !== 7'b11_00_00_0) begin
                errors++;
                $display("[TB] FAIL rstval_quiet cyc %0d: FILT/RISE/FALL/ANY got %b expected 1100000",
                         i, {filt1, rise1, fall1, any1});
            end
        end
        async1 = 2'b00;
        for (int c = 1; c <= 10; c++) begin
            tick();
            checks++;
            if ({filt1, rise1, fall1, any1} !==
                {((c >= N1 + F1) ? 2'b00 : 2'b11), 2'b00, ((c == N1 + F1) ? 3'b11_1 : 3'b00_0)}) begin
                errors++;
                $display("[TB] FAIL rstval_fall edge %0d: FILT/RISE/FALL/ANY got %b", c, {filt1, rise1, fall1, any1});
            end
        end
    endtask

    initial begin
        test_reset();
        test_rise_latency();
        test_short_pulse();
        test_multi_channel();
        test_enable();
        test_reset_mid();
        test_random();
        test_rstval_one();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
